apb_ram_ws: RTL

- Parametrised APB slave RAM for the RISC-V peripheral bus.
- Successor to the fixed 16-word single-cycle RAM.
- Adds:
  - configurable data width and depth
  - byte-lane write strobes
  - programmable wait states via an internal counter/FSM
  - PSLVERR for out-of-range or misaligned accesses
- Sits behind the APB decoder on one PSEL line; PADDR is the full 32-bit bus address and only the low ADDR_W bits are decoded here.

---
 rtl/apb_ram_ws.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/apb_ram_ws.sv
// apb_ram_ws: APB slave RAM with byte strobes, programmable wait states and
// PSLVERR for misaligned or out-of-range word accesses. Only the low ADDR_W
// bits of PADDR are decoded; the upper bits belong to the system decoder.
`timescale 1ns/1ps

module apb_ram_ws #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [31:0]         PADDR,
    input  logic                PWRITE,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - LSB;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WS_M1  = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
    localparam logic [3:0]     CNT_LOAD = 4'(WS_M1);
    localparam logic           NO_WAIT  = (WAIT_STATES == 32'sd0);
    // One extra bit so DEPTH == 2**IDX_W is still representable.
    localparam logic [IDX_W:0] DEPTH_C  = DEPTH[IDX_W:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 state_r;
    logic [3:0]             cnt_r;
    logic [MEM_AW-1:0]      idx_r;
    logic                   wr_r;
    logic [DATA_W-1:0]      wdata_r;
    logic [STRB_W-1:0]      strb_r;
    logic                   err_r;

    logic [DATA_W-1:0]      mem_r [DEPTH];

    logic [IDX_W-1:0]       idx_full_s;
    logic                   mis_s;
    logic                   range_err_s;
    logic                   live_err_s;
    logic                   unused_addr_s;

    logic                   accept_raw_s;
    logic                   go_raw_s;
    logic                   accept_s;
    logic                   go_resp_s;
    logic [MEM_AW-1:0]      acc_idx_s;
    logic                   acc_wr_s;
    logic [DATA_W-1:0]      acc_wdata_s;
    logic [STRB_W-1:0]      acc_strb_s;
    logic                   acc_err_s;

    assign idx_full_s    = PADDR[ADDR_W-1:LSB];
    assign mis_s         = |PADDR[LSB-1:0];
    assign range_err_s   = ({1'b0, idx_full_s} >= DEPTH_C);
    assign live_err_s    = mis_s | range_err_s;
    assign unused_addr_s = ^PADDR[31:ADDR_W];

    // Reset cancels any commit or response decided this cycle.
    assign accept_s  = accept_raw_s & ~PRESET;
    assign go_resp_s = go_raw_s & ~PRESET;

    // Decide whether the coming edge enters RESP, and with which transfer
    // attributes: the live bus when a zero-wait access is accepted straight
    // from IDLE, otherwise the values captured at the first access cycle.
    always_comb begin
        accept_raw_s = 1'b0;
        go_raw_s     = 1'b0;
        acc_idx_s    = idx_r;
        acc_wr_s     = wr_r;
        acc_wdata_s  = wdata_r;
        acc_strb_s   = strb_r;
        acc_err_s    = err_r;
        case (state_r)
            ST_IDLE: begin
                if (PSEL && PENABLE) begin
                    accept_raw_s = 1'b1;
                    go_raw_s     = NO_WAIT;
                    acc_idx_s    = idx_full_s[MEM_AW-1:0];
                    acc_wr_s     = PWRITE;
                    acc_wdata_s  = PWDATA;
                    acc_strb_s   = PSTRB;
                    acc_err_s    = live_err_s;
                end else begin
                    accept_raw_s = 1'b0;
                    go_raw_s     = 1'b0;
                end
            end
            ST_WAIT: begin
                if (PSEL && (cnt_r == 4'd0)) begin
                    go_raw_s = 1'b1;
                end else begin
                    go_raw_s = 1'b0;
                end
            end
            ST_RESP: begin
                go_raw_s = 1'b0;
            end
            default: begin
                go_raw_s = 1'b0;
            end
        endcase
    end

    // Transfer FSM: capture at the first access cycle, count wait states,
    // and drive the registered response on the edge entering RESP.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= {MEM_AW{1'b0}};
            wr_r    <= 1'b0;
            wdata_r <= {DATA_W{1'b0}};
            strb_r  <= {STRB_W{1'b0}};
            err_r   <= 1'b0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= {DATA_W{1'b0}};
        end else begin
            PREADY  <= go_resp_s;
            PSLVERR <= go_resp_s & acc_err_s;
            if (go_resp_s && acc_err_s) begin
                PRDATA <= {DATA_W{1'b0}};
            end else if (go_resp_s && !acc_wr_s) begin
                PRDATA <= mem_r[acc_idx_s];
            end else begin
                PRDATA <= PRDATA;
            end

            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        idx_r   <= acc_idx_s;
                        wr_r    <= acc_wr_s;
                        wdata_r <= acc_wdata_s;
                        strb_r  <= acc_strb_s;
                        err_r   <= acc_err_s;
                        if (NO_WAIT) begin
                            state_r <= ST_RESP;
                        end else begin
                            cnt_r   <= CNT_LOAD;
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // A master that drops PSEL mid-transfer loses the transfer.
                    if (!PSEL) begin
                        cnt_r   <= 4'd0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r == 4'd0) begin
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte-lane write port, committed on the edge that raises PREADY.
    always_ff @(posedge PCLK) begin
        if (go_resp_s && acc_wr_s && !acc_err_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (acc_strb_s[b]) begin
                    mem_r[acc_idx_s][b*8 +: 8] <= acc_wdata_s[b*8 +: 8];
                end else begin
                    mem_r[acc_idx_s][b*8 +: 8] <= mem_r[acc_idx_s][b*8 +: 8];
                end
            end
        end
    end

endmodule
